// File: rtl/regfile_dump_pkg.sv
// Shared types and sizing helpers for the register file with dump port.
package regfile_dump_pkg;

  localparam int BYTE_W = 8;

  // Dump sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } dump_state_e;

  // Number of display lanes in one register word.
  function automatic int lane_count(input int data_w, input int led_w);
    return data_w / led_w;
  endfunction

  // Width of the lane select; never narrower than one bit.
  function automatic int sel_width(input int nl);
    return (nl <= 1) ? 1 : $clog2(nl);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Register storage split into byte banks, with byte-enable writes and three
// combinational read ports (A, B and the dump pointer). Register 0 can be
// hard-wired to zero.
module regfile_core
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  localparam int NB     = DATA_W / BYTE_W,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [NB-1:0]     wbe_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  input  logic [ADDR_W-1:0] raddr_d_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_d_o
);

  localparam bit ZERO_EN = (ZERO_R0 != 0);

  logic wr_en;
  logic zero_a;
  logic zero_b;
  logic zero_d;

  assign wr_en  = we_i && !(ZERO_EN && (waddr_i == '0));
  assign zero_a = ZERO_EN && (raddr_a_i == '0);
  assign zero_b = ZERO_EN && (raddr_b_i == '0);
  assign zero_d = ZERO_EN && (raddr_d_i == '0);

  for (genvar gi = 0; gi < NB; gi++) begin : g_bank
    logic [BYTE_W-1:0] bank_q [DEPTH];

    // One byte lane of every register; cleared on reset, written when its enable is set.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        for (int r = 0; r < DEPTH; r++) begin
          bank_q[r] <= '0;
        end
      end else if (wr_en && wbe_i[gi]) begin
        bank_q[waddr_i] <= wdata_i[gi*BYTE_W +: BYTE_W];
      end
    end

    assign rdata_a_o[gi*BYTE_W +: BYTE_W] = zero_a ? '0 : bank_q[raddr_a_i];
    assign rdata_b_o[gi*BYTE_W +: BYTE_W] = zero_b ? '0 : bank_q[raddr_b_i];
    assign rdata_d_o[gi*BYTE_W +: BYTE_W] = zero_d ? '0 : bank_q[raddr_d_i];
  end

endmodule

// File: rtl/regfile_dump.sv
// Two-read-port register file with write bypass, a lane display mux on port A
// and a valid/ready sequencer that streams out every register in order.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int LED_W   = 8,
  parameter int ZERO_R0 = 1,
  localparam int NL     = lane_count(DATA_W, LED_W),
  localparam int SEL_W  = sel_width(NL),
  localparam int NB     = DATA_W / BYTE_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              We,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [DATA_W-1:0] Wdata,
  input  logic [NB-1:0]     Wbe,
  input  logic [ADDR_W-1:0] Raddr_A,
  input  logic [ADDR_W-1:0] Raddr_B,
  output logic [DATA_W-1:0] Rdata_A,
  output logic [DATA_W-1:0] Rdata_B,
  input  logic [SEL_W-1:0]  Sel,
  output logic [LED_W-1:0]  LED,
  input  logic              Dump_Start,
  output logic              Dump_Valid,
  input  logic              Dump_Ready,
  output logic [ADDR_W-1:0] Dump_Addr,
  output logic [DATA_W-1:0] Dump_Data,
  output logic              Busy
);

  localparam bit                ZERO_EN  = (ZERO_R0 != 0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;
  logic [DATA_W-1:0] core_d;
  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;
  logic              wr_ok;
  logic              hit_a;
  logic              hit_b;

  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;

  dump_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] dump_addr_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              dump_valid_q;
  logic              busy_q;

  regfile_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_core (
    .Clk       (Clk),
    .Reset     (Reset),
    .we_i      (We),
    .waddr_i   (Waddr),
    .wdata_i   (Wdata),
    .wbe_i     (Wbe),
    .raddr_a_i (Raddr_A),
    .raddr_b_i (Raddr_B),
    .raddr_d_i (ptr_q),
    .rdata_a_o (core_a),
    .rdata_b_o (core_b),
    .rdata_d_o (core_d)
  );

  // A write to register 0 never lands, so it must not be forwarded either.
  assign wr_ok = We && !(ZERO_EN && (Waddr == '0));
  assign hit_a = wr_ok && (Waddr == Raddr_A);
  assign hit_b = wr_ok && (Waddr == Raddr_B);

  for (genvar gi = 0; gi < NB; gi++) begin : g_bypass
    assign byp_a[gi*BYTE_W +: BYTE_W] = (hit_a && Wbe[gi]) ? Wdata[gi*BYTE_W +: BYTE_W]
                                                           : core_a[gi*BYTE_W +: BYTE_W];
    assign byp_b[gi*BYTE_W +: BYTE_W] = (hit_b && Wbe[gi]) ? Wdata[gi*BYTE_W +: BYTE_W]
                                                           : core_b[gi*BYTE_W +: BYTE_W];
  end

  // Registered read ports carrying the post-write merged word on an address match.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      rdata_a_q <= byp_a;
      rdata_b_q <= byp_b;
    end
  end

  assign Rdata_A = rdata_a_q;
  assign Rdata_B = rdata_b_q;

  logic [LED_W-1:0] lanes [NL];
  logic [LED_W-1:0] led_sel;

  for (genvar gi = 0; gi < NL; gi++) begin : g_lane
    assign lanes[gi] = rdata_a_q[gi*LED_W +: LED_W];
  end

  // Display mux: an out-of-range select shows a dark display.
  always_comb begin
    led_sel = '0;
    if (int'(Sel) < NL) begin
      led_sel = lanes[Sel];
    end
  end

  assign LED = led_sel;

  // Dump sequencer: LOAD snapshots one register, SEND holds it until accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Dump_Start) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          dump_data_q  <= core_d;
          dump_addr_q  <= ptr_q;
          dump_valid_q <= 1'b1;
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          if (Dump_Ready) begin
            dump_valid_q <= 1'b0;
            if (ptr_q == PTR_LAST) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              ptr_q   <= ptr_q + PTR_ONE;
              state_q <= ST_LOAD;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          dump_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign Dump_Valid = dump_valid_q;
  assign Dump_Addr  = dump_addr_q;
  assign Dump_Data  = dump_data_q;
  assign Busy       = busy_q;

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits; SHALL be a multiple of 8 and of LED_W.
REQ-002 Parameter ADDR_W, default 5: address width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter LED_W, default 8: width of one display lane; lane count NL = DATA_W/LED_W.
REQ-004 Parameter ZERO_R0, default 1: 1 = register 0 reads zero and ignores writes.
REQ-005 Clk  input  1  clock; all state updates on rising edge.
REQ-006 Reset  input  1  reset, asynchronous, active-high.
REQ-007 We  input  1  write enable.
REQ-008 Waddr  input  ADDR_W  write address.
REQ-009 Wdata  input  DATA_W  write data.
REQ-010 Wbe  input  DATA_W/8  byte write enables; bit k covers Wdata[8k+7:8k].
REQ-011 Raddr_A, Raddr_B  input  ADDR_W  read addresses, ports A and B.
REQ-012 Rdata_A, Rdata_B  output  DATA_W  registered read data.
REQ-013 Sel  input  max(1,clog2(NL))  display lane select.
REQ-014 LED  output  LED_W  lane Sel of Rdata_A.
REQ-015 Dump_Start  input  1  single-cycle request to stream out all registers.
REQ-016 Dump_Valid  output  1  dump word valid.
REQ-017 Dump_Ready  input  1  consumer accepts dump word.
REQ-018 Dump_Addr  output  ADDR_W  address of current dump word.
REQ-019 Dump_Data  output  DATA_W  current dump word.
REQ-020 Busy  output  1  dump in progress.

Function
REQ-021 Write: when We=1, each byte k with Wbe[k]=1 SHALL be updated in register Waddr at the clock edge; bytes with Wbe[k]=0 unchanged.
REQ-022 When ZERO_R0=1, writes to address 0 SHALL be discarded and all reads of address 0 (ports A, B, dump) SHALL return 0.
REQ-023 Read latency: Rdata_A/B SHALL present contents of Raddr_A/B sampled at edge N, valid after edge N (one cycle).
REQ-024 Bypass: if We=1 and Waddr equals a read address in the same cycle, that port SHALL return the post-write merged word (old bytes where Wbe=0, new where Wbe=1), subject to REQ-022.
REQ-025 LED SHALL equal Rdata_A[(Sel+1)*LED_W-1 : Sel*LED_W], combinational from Rdata_A and Sel; Sel >= NL SHALL give LED=0.
REQ-026 Dump FSM states: IDLE, LOAD, SEND.
REQ-027 IDLE: Busy=0, Dump_Valid=0; Dump_Start=1 -> LOAD with dump pointer = 0.
REQ-028 LOAD (one cycle): Dump_Data <- stored contents of pointer before any same-cycle write; Dump_Addr <- pointer; -> SEND.
REQ-029 SEND: Dump_Valid=1; Dump_Data/Dump_Addr SHALL stay stable while Dump_Ready=0; on Dump_Ready=1, pointer = max -> IDLE, else pointer+1 -> LOAD.
REQ-030 Busy SHALL be 1 in LOAD and SEND.
REQ-031 Dump_Start while Busy=1 SHALL be ignored.
REQ-032 Normal reads and writes SHALL continue unaffected during a dump; a write to an address already loaded SHALL NOT alter the emitted word.
REQ-033 Dump throughput: one word per 2 cycles with Dump_Ready held 1; full dump of 2**ADDR_W words SHALL take 2*2**ADDR_W cycles from Dump_Start to Busy=0.

Reset
REQ-034 Reset=1 SHALL asynchronously clear all registers, Rdata_A, Rdata_B, Dump_Data, Dump_Addr, dump pointer to 0, FSM to IDLE; hence LED=0, Dump_Valid=0, Busy=0.
REQ-035 Reset asserted mid-dump SHALL abort the dump with no further Dump_Valid.

Structure
REQ-036 Shared package SHALL hold the dump state enumeration and the lane-count/select-width helper constants.
REQ-037 Storage array with byte-enable write SHALL be one sub-module, regfile_core; bypass, LED mux and dump FSM live in regfile_dump.

Verification
REQ-038 Write 0x12345678 to r3 (Wbe=1111), read A=3 next cycle -> Rdata_A=0x12345678; Sel=0..3 -> LED=0x78,0x56,0x34,0x12.
REQ-039 r5=0x7FFFFFFF, write 0x000000AA Wbe=0001 with Raddr_B=5 same cycle -> Rdata_B=0x7FFFFFAA next cycle (bypass).
REQ-040 Write 0x10010000 to r0 -> Rdata_A for address 0 = 0; dump word 0 = 0.
REQ-041 Preload r1=0x33332222, Dump_Start, Dump_Ready=1 -> words addr 0..31 in order, addr 1 = 0x33332222, Busy low 64 cycles after start.
REQ-042 During dump hold Dump_Ready=0 for 5 cycles at addr 4 and write r4 -> Dump_Data stable at pre-write value; second Dump_Start ignored.
REQ-043 Assert Reset mid-dump at addr 10 -> Busy=0, Dump_Valid=0, all reads return 0.
